// File: rtl/fa_serial_sched.sv
// Bit-serial add/subtract engine shared by two requesters. A round-robin arbiter
// feeds one full adder that walks the operands LSB-first, one bit per cycle.
module fa_serial_sched #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_sub,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_sub,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_id,
  output logic [W-1:0] res_sum,
  output logic         res_carry
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic           id_q, id_d;
  logic           last_q, last_d;
  logic           res_valid_q, res_valid_d;

  logic           grant0, grant1, winner, win_sub;
  logic           fa_s, fa_c;
  logic [W-1:0]   s_vec;

  // On contention the requester not served last wins. Ready is gated by rst_n
  // because the state already reads IDLE while reset is still asserted.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_q);
    grant1     = req1_valid && (!req0_valid || !last_q);
    req0_ready = rst_n && (state_q == IDLE) && grant0;
    req1_ready = rst_n && (state_q == IDLE) && grant1;
  end

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    id_d     = id_q;
    last_d   = last_q;

    fa_s     = a_q[0] ^ b_q[0] ^ carry_q;
    fa_c     = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    s_vec    = '0;
    s_vec[W-1] = fa_s;

    winner   = req1_ready;
    win_sub  = winner ? req1_sub : req0_sub;

    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          a_d     = winner ? req1_a : req0_a;
          b_d     = winner ? req1_b : req0_b;
          // Subtract as a + ~b + 1: invert b and seed the carry with 1.
          if (win_sub) b_d = ~b_d;
          carry_d = win_sub;
          cnt_d   = '0;
          id_d    = winner;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = (sum_q >> 1) | s_vec;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = DONE;
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
          last_d  = id_q;
        end
      end
      default: state_d = IDLE;
    endcase

    res_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      id_q        <= id_d;
      last_q      <= last_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = sum_q;
  assign res_carry = carry_q;
  assign res_id    = id_q;

endmodule

// File: tb/tb_fa_serial_sched.sv
// Directed bench for fa_serial_sched (W=8): vector table, round-robin contention,
// result backpressure and reset in the middle of an operation.
module tb_fa_serial_sched;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_sub;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_sub;
  logic [W-1:0] req1_a, req1_b;
  logic         res_valid, res_ready, res_id, res_carry;
  logic [W-1:0] res_sum;

  int n_checks = 0;
  int n_fail   = 0;

  fa_serial_sched #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_sum    (res_sum),
    .res_carry  (res_carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_carry;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Present one op on a single requester, wait for acceptance, then count
  // cycles from the acceptance edge until res_valid is seen.
  task automatic run_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, output int lat);
    bit ok;
    if (id) begin req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1; end
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((id ? req1_ready : req0_ready) === 1'b1) begin ok = 1'b1; break; end
    end
    check("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (res_valid !== 1'b1 && lat < 50) begin
      lat++;
      @(negedge clk);
    end
  endtask

  vec_t          vecs[7];
  int            lat;
  bit            ok;
  logic          g;
  logic [W-1:0]  ea, eb, exp_sum;
  logic          es, exp_carry;
  time           t_acc, t_prev;
  int            seen;

  initial begin
    vecs[0] = '{1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0};
    vecs[4] = '{1'b1, 8'h20, 8'h10, 1'b1, 8'h10, 1'b1};
    vecs[5] = '{1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1};

    req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    res_ready = 1'b1;
    rst_n = 1'b0;

    // Reset state, with both valids high to prove ready stays low in reset.
    #12;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_sum", 32'(res_sum), 32'd0);
    check("rst_res_carry", 32'(res_carry), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sub, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(W));
      check($sformatf("vec%0d_sum", i), 32'(res_sum), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d_carry", i), 32'(res_carry), 32'(vecs[i].exp_carry));
      check($sformatf("vec%0d_id", i), 32'(res_id), 32'(vecs[i].id));
    end

    // Contention: fresh reset, both valids held high, results streamed out.
    @(posedge clk);
    #1 apply_reset();
    req0_a = 8'($urandom); req0_b = 8'($urandom); req0_sub = 1'($urandom);
    req1_a = 8'($urandom); req1_b = 8'($urandom); req1_sub = 1'($urandom);
    req0_valid = 1'b1; req1_valid = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 6; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (req0_ready === 1'b1 || req1_ready === 1'b1) begin ok = 1'b1; break; end
      end
      check("cont_accept_timeout", 32'(ok), 32'd1);
      check($sformatf("cont%0d_ready0", k), 32'(req0_ready), 32'(k % 2 == 0));
      check($sformatf("cont%0d_ready1", k), 32'(req1_ready), 32'(k % 2 == 1));
      g  = (k % 2 == 1);
      ea = g ? req1_a : req0_a;
      eb = g ? req1_b : req0_b;
      es = g ? req1_sub : req0_sub;
      exp_sum   = es ? ea - eb : ea + eb;
      exp_carry = es ? (ea >= eb) : ((9'(ea) + 9'(eb)) > 9'd255);
      @(posedge clk);
      t_acc = $time;
      if (k > 0) check($sformatf("cont%0d_interval", k), 32'((t_acc - t_prev) / 10), 32'(W + 2));
      t_prev = t_acc;
      #1;
      if (g) begin req1_a = 8'($urandom); req1_b = 8'($urandom); req1_sub = 1'($urandom); end
      else   begin req0_a = 8'($urandom); req0_b = 8'($urandom); req0_sub = 1'($urandom); end
      lat = 0;
      @(negedge clk);
      while (res_valid !== 1'b1 && lat < 50) begin lat++; @(negedge clk); end
      check($sformatf("cont%0d_latency", k), 32'(lat), 32'(W));
      check($sformatf("cont%0d_sum", k), 32'(res_sum), 32'(exp_sum));
      check($sformatf("cont%0d_carry", k), 32'(res_carry), 32'(exp_carry));
      check($sformatf("cont%0d_id", k), 32'(res_id), 32'(g));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    #1;

    // Backpressure: result held for 5 extra cycles while both requesters wait.
    res_ready = 1'b0;
    run_op(1'b0, 8'h12, 8'h34, 1'b0, lat);
    check("bp_latency", 32'(lat), 32'(W));
    check("bp_sum_first", 32'(res_sum), 32'h46);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d_valid", i), 32'(res_valid), 32'd1);
      check($sformatf("bp%0d_sum", i), 32'(res_sum), 32'h46);
      check($sformatf("bp%0d_carry", i), 32'(res_carry), 32'd0);
      check($sformatf("bp%0d_id", i), 32'(res_id), 32'd0);
      check($sformatf("bp%0d_ready0", i), 32'(req0_ready), 32'd0);
      check($sformatf("bp%0d_ready1", i), 32'(req1_ready), 32'd0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(res_valid), 32'd0);

    // Reset while RUN has cnt == 3, on a requester-1 op so res_id is nonzero.
    run_op_start: begin
      req1_a = 8'hFF; req1_b = 8'hFF; req1_sub = 1'b0; req1_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (req1_ready === 1'b1) begin ok = 1'b1; break; end
      end
      check("mid_accept_timeout", 32'(ok), 32'd1);
      @(posedge clk);
      #1 req1_valid = 1'b0;
      repeat (4) @(negedge clk);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_sum", 32'(res_sum), 32'd0);
    check("mid_rst_carry", 32'(res_carry), 32'd0);
    check("mid_rst_id", 32'(res_id), 32'd0);
    check("mid_rst_ready0", 32'(req0_ready), 32'd0);
    check("mid_rst_ready1", 32'(req1_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_post_ready0", 32'(req0_ready), 32'd1);
    check("mid_post_ready1", 32'(req1_ready), 32'd0);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0) seen++;
    end
    check("mid_no_result", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fa_serial_sched.md
# fa_serial_sched

Bit-serial add/subtract scheduler that shares one single-bit full-adder datapath between two requesters. It arbitrates the requesters round-robin, accepts one W-bit operation at a time, and sequences the full adder LSB-first over W cycles with a carry flip-flop. It returns the W-bit result, carry-out and requester ID on a valid/ready result port. It sits between operand producers and the compact adder datapath wherever area outweighs throughput.

## Interface
- W, default 8: operand/result width in bits; legal W >= 1.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle (when req0_valid is high).
- req0_a, req0_b  in  W each  requester 0 operands.
- req0_sub  in  1  requester 0 mode: 0 computes a+b, 1 computes a-b.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same meanings for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer accepts the result.
- res_id  out  1  index of the requester that issued the result.
- res_sum  out  W  result, modulo 2^W.
- res_carry  out  1  final carry-out; in sub mode, 1 means no borrow (a >= b unsigned).

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE
  - If neither valid is high: stay in IDLE.
  - If only one valid is high: that requester is the winner.
  - If both are high: the winner is the requester not served last (`last` register).
  - Winner's ready = 1; the other ready = 0.
  - On valid&ready:
    - A <= a.
    - B <= b (inverted if sub).
    - carry <= sub.
    - cnt <= 0.
    - id <= winner.
    - Go to RUN.
- RUN, each cycle:
  - Full adder computes s = A[0]^B[0]^carry and cout = majority(A[0], B[0], carry).
  - Shift s into the sum register at the MSB, shift right.
  - Shift A and B right by one.
  - carry <= cout.
  - cnt <= cnt+1.
  - When cnt == W-1 (the last bit), go to DONE.
- DONE
  - res_valid = 1.
  - res_sum, res_carry and res_id are held stable.
  - When res_ready is high: go to IDLE and set last <= id.
- Ready outputs are 0 in RUN and DONE, and 0 while rst_n is low.
- Operand inputs are sampled only at acceptance; later changes to them have no effect.
- Bit counter width: clog2(W+1).
- Reset values:
  - res_valid = 0, res_sum = 0, res_carry = 0, res_id = 0, req0_ready = 0, req1_ready = 0.
  - last = 1, so requester 0 wins the first contention.
  - A, B, carry and cnt = 0.
- Reset mid-operation (RUN or DONE): the operation is discarded with no result. Outputs go to their reset values immediately (asynchronously). After release the FSM is in IDLE.
- W = 1: RUN lasts exactly one cycle.

## Timing
- Acceptance happens at rising edge t0, where IDLE and valid&ready are both true.
- RUN occupies edges t0+1 through t0+W.
- res_valid is high from t0+W, i.e. visible in the cycle after the final RUN edge.
- Latency from acceptance edge to res_valid: W cycles.
- If res_ready is high in the first DONE cycle, the FSM returns to IDLE at t0+W+1. The next acceptance can happen at t0+W+2.
- Maximum throughput: one operation per W+2 cycles.
- Arbitration and the ready outputs are combinational from the state, `last`, and both valids; there is no registered grant.
- Result handshake completes on a rising edge where res_valid and res_ready are both high.
- res_valid never drops without that handshake, except on reset.

## Test plan
- Add: W=8, req0 a=0x5A, b=0x3C, sub=0. Required: res_sum=0x96, res_carry=0, res_id=0, res_valid rising exactly 8 cycles after the acceptance edge.
- Wrap-around: 0xFF+0x01 gives res_sum=0x00 and res_carry=1. Also 0x00+0x00 gives 0x00 with carry 0.
- Subtract on req1: 0x10-0x20 gives res_sum=0xF0, res_carry=0. Then 0x20-0x10 gives res_sum=0x10, res_carry=1. res_id=1 for both.
- Contention: both valids held high with random operands and res_ready tied to 1.
  - Grants alternate 0,1,0,1,… starting with 0 after reset.
  - Ops complete every 10 cycles.
  - Results match a golden model.
- Backpressure: hold res_ready=0 for 5 cycles in DONE. Required:
  - res_valid, res_sum, res_carry and res_id stay stable.
  - Both readies stay 0 and no new acceptance occurs.
  - The op completes on the cycle res_ready rises.
- Reset mid-RUN: assert rst_n=0 at cnt=3. Required:
  - All outputs are 0 immediately and no result is ever produced.
  - After release, with both valids high, requester 0 is granted first.
